// File: rtl/buzz_pkg.sv
// Shared definitions for the quiz responder: FSM states, scorer player codes
// and the binary-to-BCD helper used for the seconds display.
package buzz_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        LOCKED = 2'b10,
        DONE   = 2'b11
    } state_e;

    localparam logic [3:0] PLAYER_NONE = 4'b0000;
    localparam logic [3:0] PLAYER_1    = 4'b0001;
    localparam logic [3:0] PLAYER_2    = 4'b0010;
    localparam logic [3:0] PLAYER_3    = 4'b0011;
    localparam logic [3:0] PLAYER_4    = 4'b0100;

    function automatic logic [7:0] bin2bcd8(input logic [6:0] bin);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
        return {tens, ones};
    endfunction

    // Fixed priority: player 1 wins any tie.
    function automatic logic [3:0] first_player(input logic [3:0] rise);
        if (rise[0])      return PLAYER_1;
        else if (rise[1]) return PLAYER_2;
        else if (rise[2]) return PLAYER_3;
        else if (rise[3]) return PLAYER_4;
        else              return PLAYER_NONE;
    endfunction

endpackage

// File: rtl/buzz_arbiter_key_cond.sv
// Key conditioner: 2-flop synchroniser, DB_CYCLES-sample debouncer and a
// registered one-cycle rise pulse on each debounced 0->1 transition.
module key_cond #(
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic rise
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts differing samples already seen; the DB_CYCLES-th one flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/buzz_arbiter.sv
// First-press arbiter: conditions the six keys, latches the first valid
// buzz (or an early foul) and runs the buzz/answer countdowns in BCD.
module buzz_arbiter
    import buzz_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned BUZZ_WINDOW   = 10,
    parameter int unsigned ANSWER_WINDOW = 20,
    parameter int unsigned DB_CYCLES     = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic [3:0] btn,
    output logic [3:0] who,
    output logic       locked,
    output logic       foul,
    output logic       timeout,
    output logic [7:0] secs_left,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [5:0] key_raw, key_rise;
    logic [3:0] btn_rise;
    logic       start_rise, clear_rise, tick;

    state_e        state_q, state_d;
    logic [3:0]    who_q, who_d;
    logic          locked_q, locked_d, foul_q, foul_d, timeout_q, timeout_d;
    logic [6:0]    secs_q, secs_d;
    logic [7:0]    secs_left_q, secs_left_d;
    logic [PW-1:0] presc_q, presc_d;

    assign key_raw = {clear, start, btn};

    for (genvar g = 0; g < 6; g++) begin : g_key
        key_cond #(.DB_CYCLES(DB_CYCLES)) u_key (
            .clk     (clk),
            .rst     (rst),
            .key_raw (key_raw[g]),
            .rise    (key_rise[g])
        );
    end

    assign btn_rise   = key_rise[3:0];
    assign start_rise = key_rise[4];
    assign clear_rise = key_rise[5];
    assign tick       = (presc_q == PW'(TICK_DIV - 1));

    // Priority: clear > press > tick > start, expressed by branch order.
    always_comb begin
        state_d   = state_q;
        who_d     = who_q;
        locked_d  = locked_q;
        foul_d    = foul_q;
        timeout_d = timeout_q;
        secs_d    = secs_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        if (clear_rise) begin
            state_d   = IDLE;
            who_d     = PLAYER_NONE;
            locked_d  = 1'b0;
            foul_d    = 1'b0;
            timeout_d = 1'b0;
            secs_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|btn_rise) begin
                        state_d = DONE;
                        foul_d  = 1'b1;
                        who_d   = first_player(btn_rise);
                        secs_d  = '0;
                    end else if (start_rise) begin
                        state_d = ARMED;
                        secs_d  = 7'(BUZZ_WINDOW);
                        presc_d = '0;
                    end
                end
                ARMED: begin
                    if (|btn_rise) begin
                        state_d  = LOCKED;
                        who_d    = first_player(btn_rise);
                        locked_d = 1'b1;
                        secs_d   = 7'(ANSWER_WINDOW);
                        presc_d  = '0;
                    end else if (tick) begin
                        if (secs_q == 7'd1) begin
                            state_d   = DONE;
                            timeout_d = 1'b1;
                            who_d     = PLAYER_NONE;
                            secs_d    = '0;
                        end else begin
                            secs_d = secs_q - 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (tick) begin
                        if (secs_q == 7'd1) begin
                            state_d   = DONE;
                            timeout_d = 1'b1;
                            locked_d  = 1'b0;
                            secs_d    = '0;
                        end else begin
                            secs_d = secs_q - 1'b1;
                        end
                    end
                end
                DONE: ;
            endcase
        end
        secs_left_d = bin2bcd8(secs_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            who_q       <= PLAYER_NONE;
            locked_q    <= 1'b0;
            foul_q      <= 1'b0;
            timeout_q   <= 1'b0;
            secs_q      <= '0;
            secs_left_q <= '0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            who_q       <= who_d;
            locked_q    <= locked_d;
            foul_q      <= foul_d;
            timeout_q   <= timeout_d;
            secs_q      <= secs_d;
            secs_left_q <= secs_left_d;
            presc_q     <= presc_d;
        end
    end

    assign who       = who_q;
    assign locked    = locked_q;
    assign foul      = foul_q;
    assign timeout   = timeout_q;
    assign secs_left = secs_left_q;
    assign state     = state_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Scoreboard bench for buzz_arbiter: expected output snapshots are queued as
// stimulus is driven and popped when the DUT reaches the awaited state.
module tb_buzz_arbiter;

    logic       clk = 1'b0;
    logic       rst, start, clear;
    logic [3:0] btn;
    logic [3:0] who;
    logic       locked, foul, timeout;
    logic [7:0] secs_left;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [16:0] v;
        logic [16:0] m;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    localparam logic [16:0] ALL     = '1;
    localparam logic [16:0] NO_SECS = 17'h1FF00;

    always #5 clk = ~clk;

    buzz_arbiter #(
        .TICK_DIV      (10),
        .BUZZ_WINDOW   (3),
        .ANSWER_WINDOW (5),
        .DB_CYCLES     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .btn       (btn),
        .who       (who),
        .locked    (locked),
        .foul      (foul),
        .timeout   (timeout),
        .secs_left (secs_left),
        .state     (state)
    );

    function automatic logic [16:0] obs();
        return {state, who, locked, foul, timeout, secs_left};
    endfunction

    function automatic logic [16:0] pack(input logic [1:0] s, input logic [3:0] w,
                                         input logic l, input logic f, input logic t,
                                         input logic [7:0] sl);
        return {s, w, l, f, t, sl};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clear = 1'b0; btn = 4'b0000;
        sb.push_back('{"reset", pack(2'b00, 4'b0000, 0, 0, 0, 8'h00), ALL});
        idle(3);
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_clear_to_idle(input string tag);
        clear = 1'b1;
        sb.push_back('{tag, pack(2'b00, 4'b0000, 0, 0, 0, 8'h00), ALL});
        wait_state(2'b00, 20);
        clear = 1'b0;
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        idle(10);
    endtask

    task automatic test_lock_hold();
        start = 1'b1;
        sb.push_back('{"armed", pack(2'b01, 4'b0000, 0, 0, 0, 8'h03), ALL});
        wait_state(2'b01, 20);
        start = 1'b0;
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        btn[2] = 1'b1;
        sb.push_back('{"lock_p3", pack(2'b10, 4'b0011, 1, 0, 0, 8'h05), ALL});
        wait_state(2'b10, 20);
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        idle(4); btn[2] = 1'b0;
        idle(8); btn[0] = 1'b1;
        idle(8); btn[0] = 1'b0;
        idle(2);
        // 22 cycles after lock: two ticks taken, 5 -> 3
        sb.push_back('{"lock_hold", pack(2'b10, 4'b0011, 1, 0, 0, 8'h03), ALL});
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        sb.push_back('{"answer_timeout", pack(2'b11, 4'b0011, 0, 0, 1, 8'h00), ALL});
        wait_state(2'b11, 60);
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        test_clear_to_idle("clear_after_answer");
    endtask

    task automatic test_simultaneous();
        int cyc = 0;
        start = 1'b1;
        wait_state(2'b01, 20);
        start = 1'b0;
        idle(8);
        btn = 4'b1010;
        sb.push_back('{"simul_p2", pack(2'b10, 4'b0010, 1, 0, 0, 8'h05), ALL});
        wait_state(2'b10, 20);
        btn = 4'b0000;
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        while (state !== 2'b11 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc !== 50) begin
            n_fail++; $display("FAIL answer_cycles: got %0d expected 50", cyc);
        end
        sb.push_back('{"simul_done", pack(2'b11, 4'b0010, 0, 0, 1, 8'h00), ALL});
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        test_clear_to_idle("clear_after_simul");
    endtask

    task automatic test_foul();
        btn[0] = 1'b1;
        sb.push_back('{"foul_p1", pack(2'b11, 4'b0001, 0, 1, 0, 8'h00), ALL});
        wait_state(2'b11, 20);
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        btn[0] = 1'b0;
        idle(8);
        start = 1'b1; idle(10); start = 1'b0; idle(8);
        sb.push_back('{"foul_ignores_start", pack(2'b11, 4'b0001, 0, 1, 0, 8'h00), ALL});
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        test_clear_to_idle("clear_after_foul");
    endtask

    task automatic test_timeout();
        logic [7:0] steps [3];
        steps[0] = 8'h02; steps[1] = 8'h01; steps[2] = 8'h00;
        start = 1'b1;
        sb.push_back('{"buzz_03", pack(2'b01, 4'b0000, 0, 0, 0, 8'h03), ALL});
        wait_state(2'b01, 20);
        start = 1'b0;
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < 2)
                sb.push_back('{$sformatf("buzz_step%0d", i), pack(2'b01, 4'b0000, 0, 0, 0, steps[i]), ALL});
            else
                sb.push_back('{"buzz_timeout", pack(2'b11, 4'b0000, 0, 0, 1, 8'h00), ALL});
            idle(10);
            e = sb.pop_front(); n_tests++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
            end
        end
        test_clear_to_idle("clear_after_timeout");
    endtask

    task automatic test_glitch_clear();
        start = 1'b1;
        wait_state(2'b01, 20);
        start = 1'b0;
        idle(2);
        btn[1] = 1'b1; idle(2); btn[1] = 1'b0;
        idle(10);
        sb.push_back('{"glitch_no_lock", pack(2'b01, 4'b0000, 0, 0, 0, 8'h00), NO_SECS});
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        clear = 1'b1; btn[2] = 1'b1;
        sb.push_back('{"clear_beats_press", pack(2'b00, 4'b0000, 0, 0, 0, 8'h00), ALL});
        wait_state(2'b00, 20);
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        idle(10);
        clear = 1'b0; btn = 4'b0000;
        idle(10);
        sb.push_back('{"held_btn_no_foul", pack(2'b00, 4'b0000, 0, 0, 0, 8'h00), ALL});
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_reset_mid_locked();
        start = 1'b1;
        wait_state(2'b01, 20);
        start = 1'b0;
        idle(8);
        btn[1] = 1'b1;
        sb.push_back('{"pre_reset_lock", pack(2'b10, 4'b0010, 1, 0, 0, 8'h05), ALL});
        wait_state(2'b10, 20);
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        #3 rst = 1'b1;
        #1;
        sb.push_back('{"async_reset", pack(2'b00, 4'b0000, 0, 0, 0, 8'h00), ALL});
        e = sb.pop_front(); n_tests++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        btn = 4'b0000; start = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(10);
    endtask

    initial begin
        test_reset();
        test_lock_hold();
        test_simultaneous();
        test_foul();
        test_timeout();
        test_glitch_clear();
        test_reset_mid_locked();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
